trap_redirect_unit: RTL
=======================

Name: trap_redirect_unit

Overview:
- Consumes the trap/return decisions made by the CSR/exception unit in the XB stage and turns them into a pipeline flush plus a fetch redirect.
- On an accepted exception it steers fetch to the trap vector (mtvec). On an accepted mret it steers fetch to the return address (mepc).
- Sits between the XB-stage EHU outputs and the FD-stage PC/fetch logic, and owns the flush/stall sequencing.

Parameters:
- FLUSH_CYCLES, 2, cycles flush is held after an event before redirect is offered (legal range 1..15).
- CNT_W, 8, width of the saturating trap counter.

Ports:
- clk  in  1  core clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- XB_bubble  in  1  XB stage holds a bubble; an mret is ignored when this is high.
- initiate_exception  in  1  EHU trap request, already qualified by ~XB_bubble.
- XB_mret  in  1  mret instruction in XB.
- csr_mtvec  in  32  trap vector base.
- csr_mepc  in  32  exception PC / return address.
- fetch_ack  in  1  fetch unit accepted the redirect this cycle.
- redirect_valid  out  1  redirect_pc is valid; held until fetch_ack.
- redirect_pc  out  32  target PC, bits [1:0] always 0.
- flush  out  1  kill FD and XB contents.
- stall  out  1  freeze PC advance.
- in_trap  out  1  handler is executing (set by exception, cleared by mret).
- trap_count  out  CNT_W  accepted exceptions, saturating.
- lost_event  out  1  sticky: a trap or mret arrived while not IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, redirect_valid=0, redirect_pc=0, flush=0, stall=0, in_trap=0, trap_count=0, lost_event=0, flush counter=0.
- States: IDLE, FLUSH, REDIRECT (encoding from the shared package).
- IDLE, event acceptance:
  - Exception: initiate_exception=1 -> latch target={csr_mtvec[31:2],2'b0}, in_trap<=1, trap_count<=trap_count+1 (saturates at all-ones), counter<=FLUSH_CYCLES-1, next state FLUSH.
  - mret: XB_mret & ~XB_bubble & ~initiate_exception -> latch target={csr_mepc[31:2],2'b0}, in_trap<=0, counter<=FLUSH_CYCLES-1, next state FLUSH.
  - Priority: exception beats mret in the same cycle.
  - mret with in_trap=0 is still honoured (returns to mepc); trap_count is unchanged.
  - Nested exception with in_trap=1: accepted normally, in_trap stays 1, target is mtvec.
- Output timing:
  - flush and stall are registered outputs, high from the cycle after the accepting edge.
  - flush is high throughout FLUSH only.
  - stall is high in FLUSH and REDIRECT.
- FLUSH: counter decrements each cycle. When counter==0, next state is REDIRECT. The FLUSH state therefore lasts exactly FLUSH_CYCLES cycles.
- REDIRECT:
  - redirect_valid=1, redirect_pc=target; target stays stable while redirect_valid is high.
  - On fetch_ack=1: next state IDLE, redirect_valid<=0, stall<=0.
  - No timeout; the state waits indefinitely for fetch_ack.
- Latency: a single event with fetch_ack tied high gives
  - redirect_valid high FLUSH_CYCLES+1 cycles after the accepting edge;
  - back in IDLE one cycle later.
- Events outside IDLE: initiate_exception or (XB_mret & ~XB_bubble) in FLUSH or REDIRECT are dropped. lost_event<=1 and stays set until reset.
- fetch_ack outside REDIRECT: ignored.
- reset mid-operation: overrides all activity; the next cycle is IDLE with outputs at reset values.
- csr_mepc and csr_mtvec are sampled only on the accepting edge; later changes do not affect the latched target.

Decomposition:
- Shared package / header holds:
  - state encoding constants TRU_IDLE, TRU_FLUSH, TRU_REDIRECT;
  - the PC alignment mask constant.
- One sub-module: sat_counter (parameterised width, inc enable, synchronous reset), used for trap_count.
- The flush down-counter stays inline.

Test Plan:
- Reset, then exception: mtvec=0x0000_0104 plus initiate_exception for one cycle, fetch_ack=1.
  - flush high for 2 cycles, then redirect_valid with redirect_pc=0x104 for 1 cycle.
  - in_trap=1, trap_count=1, IDLE 4 cycles after the pulse.
- mret after the handler: mepc=0x0000_0203, XB_mret=1, XB_bubble=0.
  - redirect_pc=0x200 (low bits forced 0), in_trap=0.
  - Repeat with XB_bubble=1 -> no flush, state stays IDLE.
- Simultaneous exception and mret, mtvec=0x4, mepc=0x80.
  - redirect_pc=0x4, in_trap=1, trap_count increments.
- Fetch backpressure: fetch_ack low for 5 cycles in REDIRECT.
  - redirect_valid and redirect_pc stay stable 5 cycles, stall high.
  - Change csr_mtvec meanwhile -> redirect_pc unchanged.
  - Ack -> IDLE next cycle.
- Event while busy: second initiate_exception during FLUSH.
  - Ignored: target unchanged, trap_count unchanged, lost_event=1 sticky until reset.
  - Synchronous reset asserted during REDIRECT -> all outputs 0 the next cycle.
- Saturation: CNT_W=2, issue 5 exceptions -> trap_count reads 3 after the 3rd and stays 3.

Source files
------------

// File: rtl/trap_redirect_unit_pkg.sv
// ------------------------------------------------------------------
// trap_redirect_unit_pkg : shared state encoding and PC alignment
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package trap_redirect_unit_pkg;

  localparam logic [1:0] TRU_IDLE     = 2'd0;
  localparam logic [1:0] TRU_FLUSH    = 2'd1;
  localparam logic [1:0] TRU_REDIRECT = 2'd2;

  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE     = TRU_IDLE,
    ST_FLUSH    = TRU_FLUSH,
    ST_REDIRECT = TRU_REDIRECT
  } tru_state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trap_redirect_unit_if.sv
// ------------------------------------------------------------------
// trap_redirect_unit_if : EHU event inputs and fetch redirect outputs
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface trap_redirect_unit_if #(
  parameter int CNT_W = 8
);
  logic             XB_bubble;
  logic             initiate_exception;
  logic             XB_mret;
  logic [31:0]      csr_mtvec;
  logic [31:0]      csr_mepc;
  logic             fetch_ack;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush;
  logic             stall;
  logic             in_trap;
  logic [CNT_W-1:0] trap_count;
  logic             lost_event;

  // master = EHU/fetch side, slave = the redirect unit
  modport master (
    output XB_bubble, initiate_exception, XB_mret, csr_mtvec, csr_mepc, fetch_ack,
    input  redirect_valid, redirect_pc, flush, stall, in_trap, trap_count, lost_event
  );

  modport slave (
    input  XB_bubble, initiate_exception, XB_mret, csr_mtvec, csr_mepc, fetch_ack,
    output redirect_valid, redirect_pc, flush, stall, in_trap, trap_count, lost_event
  );
endinterface

`default_nettype wire

// File: rtl/trap_redirect_unit_sat_counter.sv
// ------------------------------------------------------------------
// sat_counter : up-counter that sticks at all-ones
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/trap_redirect_unit.sv
// ------------------------------------------------------------------
// trap_redirect_unit : turns trap/mret decisions into flush + fetch redirect
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module trap_redirect_unit
  import trap_redirect_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic reset,
  trap_redirect_unit_if.slave bus
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  tru_state_e  state, state_next;
  logic [3:0]  flush_cnt, flush_cnt_next;
  logic [31:0] target, target_next;
  logic        in_trap_q, in_trap_next;
  logic        flush_q, stall_q, redirect_valid_q, lost_q;
  logic        mret_req, accept_exc, accept_mret, busy_event;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    target_next    = target;
    in_trap_next   = in_trap_q;
    mret_req       = bus.XB_mret & ~bus.XB_bubble;
    accept_exc     = 1'b0;
    accept_mret    = 1'b0;
    busy_event     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.initiate_exception) begin
          accept_exc     = 1'b1;
          target_next    = align_pc(bus.csr_mtvec);
          in_trap_next   = 1'b1;
          flush_cnt_next = FLUSH_LOAD;
          state_next     = ST_FLUSH;
        end else if (mret_req) begin
          accept_mret    = 1'b1;
          target_next    = align_pc(bus.csr_mepc);
          in_trap_next   = 1'b0;
          flush_cnt_next = FLUSH_LOAD;
          state_next     = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        busy_event = bus.initiate_exception | mret_req;
        if (flush_cnt == 4'd0) begin
          state_next = ST_REDIRECT;
        end else begin
          flush_cnt_next = flush_cnt - 4'd1;
        end
      end
      ST_REDIRECT: begin
        busy_event = bus.initiate_exception | mret_req;
        if (bus.fetch_ack) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered decodes of the next state, so they track state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt        <= 4'd0;
      target           <= 32'd0;
      in_trap_q        <= 1'b0;
      flush_q          <= 1'b0;
      stall_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      lost_q           <= 1'b0;
    end else begin
      flush_cnt        <= flush_cnt_next;
      target           <= target_next;
      in_trap_q        <= in_trap_next;
      flush_q          <= (state_next == ST_FLUSH);
      stall_q          <= (state_next != ST_IDLE);
      redirect_valid_q <= (state_next == ST_REDIRECT);
      lost_q           <= lost_q | busy_event;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_trap_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (accept_exc),
    .count (bus.trap_count)
  );

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = target;
  assign bus.flush          = flush_q;
  assign bus.stall          = stall_q;
  assign bus.in_trap        = in_trap_q;
  assign bus.lost_event     = lost_q;

  logic unused_accept_mret;
  assign unused_accept_mret = accept_mret;

endmodule

`default_nettype wire
